// File: rtl/taylor_cos_ctrl.sv
// taylor_cos_ctrl: front/back-end controller around the 4-stage taylor_cos core.
// Reduces integer-degree angles to a first-quadrant reference, drives the core
// with Q1.7 radians, tracks each token through the core latency with a tag
// shift register, re-applies the quadrant sign and buffers results in a FIFO.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high; valid, once raised by a producer, carries its payload
// unchanged until that transfer; ready never depends combinationally on valid.
module taylor_cos_ctrl #(
   parameter int CORE_LAT   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk_80,
   input  logic       rst_80,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] in_deg,
   output logic [7:0] radian_80,
   output logic [7:0] factorial2_80,
   output logic [7:0] factorial4_80,
   input  logic [7:0] cos_value_80,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_cos,
   output logic       out_err
);

   localparam int TAGS = CORE_LAT + 1;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;
   localparam int IW   = $clog2(TAGS + 1);
   localparam int SW   = CW + 1;

   logic [1:0]      rst_sync;
   logic            rst_n_i;
   logic [8:0]      ref_deg;
   logic            ref_neg;
   logic            ref_err;
   logic [15:0]     rad_calc;
   logic            accept;
   logic [TAGS-1:0] tag_v;
   logic [TAGS-1:0] tag_n;
   logic [TAGS-1:0] tag_e;
   logic [IW-1:0]   inflight;
   logic            push;
   logic            pop;
   logic [8:0]      push_cos;
   logic [9:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   fifo_count;

   assign factorial2_80 = 8'd2;
   assign factorial4_80 = 8'd24;

   // Assert internal reset immediately, release it two clocks after rst_80 rises.
   always_ff @(posedge clk_80 or negedge rst_80) begin
      if (!rst_80) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_i = rst_sync[1];

   // Fold the angle into the first quadrant and remember the sign of cosine.
   always_comb begin
      ref_deg = '0;
      ref_neg = 1'b0;
      ref_err = 1'b0;
      if (in_deg < 9'd90) begin
         ref_deg = in_deg;
      end else if (in_deg < 9'd180) begin
         ref_deg = 9'd180 - in_deg;
         ref_neg = 1'b1;
      end else if (in_deg < 9'd270) begin
         ref_deg = in_deg - 9'd180;
         ref_neg = 1'b1;
      end else if (in_deg < 9'd360) begin
         ref_deg = 9'd360 - in_deg;
      end else begin
         ref_err = 1'b1;
      end
   end

   // 143/64 approximates pi/180 * 128; +32 rounds. ref <= 90 keeps this in 8 bits.
   assign rad_calc = ({7'd0, ref_deg} * 16'd143) + 16'd32;

   // Credits: every accepted token already owns a FIFO slot before it returns.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < TAGS; i++) inflight = inflight + IW'(tag_v[i]);
   end
   assign in_ready = rst_n_i && ((SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;

   // Core operand register and tag pipeline, advancing every cycle.
   always_ff @(posedge clk_80 or negedge rst_n_i) begin
      if (!rst_n_i) begin
         radian_80 <= '0;
         tag_v     <= '0;
         tag_n     <= '0;
         tag_e     <= '0;
      end else begin
         if (accept) radian_80 <= rad_calc[13:6];
         tag_v <= {tag_v[TAGS-2:0], accept};
         tag_n <= {tag_n[TAGS-2:0], accept && ref_neg};
         tag_e <= {tag_e[TAGS-2:0], accept && ref_err};
      end
   end

   // Tail of the tag pipe lines up with the core's stage4 output.
   assign push = tag_v[TAGS-1];
   always_comb begin
      push_cos = {1'b0, cos_value_80};
      if (tag_n[TAGS-1]) push_cos = 9'd0 - {1'b0, cos_value_80};
      if (tag_e[TAGS-1]) push_cos = '0;
   end

   assign pop = out_valid && out_ready;

   // FIFO storage; contents are don't-care until the count covers them.
   always_ff @(posedge clk_80) begin
      if (push) mem[wr_ptr] <= {tag_e[TAGS-1], push_cos};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_80 or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // First-word fall-through head; zero whenever the FIFO is empty.
   assign out_valid = (fifo_count != '0);
   assign out_cos   = out_valid ? mem[rd_ptr][8:0] : 9'd0;
   assign out_err   = out_valid ? mem[rd_ptr][9]   : 1'b0;

   fifo_no_overflow : assert property (@(posedge clk_80) disable iff (!rst_n_i)
      !(push && (fifo_count == CW'(FIFO_DEPTH))))
      else $error("taylor_cos_ctrl: push into full fifo");

endmodule

// File: tb/tb_taylor_cos_ctrl.sv
// Bench for taylor_cos_ctrl: directed vector table plus hand-written
// backpressure, random and mid-operation reset sequences. A behavioural
// 4-stage core stands in for taylor_cos.
module tb_taylor_cos_ctrl;

   logic       clk_80    = 1'b0;
   logic       rst_80    = 1'b0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b0;
   logic [8:0] in_deg    = '0;
   logic       in_ready;
   logic [7:0] radian_80;
   logic [7:0] factorial2_80;
   logic [7:0] factorial4_80;
   logic [7:0] cos_value_80;
   logic       out_valid;
   logic [8:0] out_cos;
   logic       out_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [9:0] exp_q[$];
   int         exp_t_q[$];

   logic [7:0] s1 = '0, s2 = '0, s3 = '0, s4 = '0;

   typedef struct {
      int         deg;
      logic [7:0] rad;
      logic       neg;
      logic       err;
   } vec_t;
   vec_t vecs[17];

   taylor_cos_ctrl #(.CORE_LAT(4), .FIFO_DEPTH(8)) dut (
      .clk_80        (clk_80),
      .rst_80        (rst_80),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_deg        (in_deg),
      .radian_80     (radian_80),
      .factorial2_80 (factorial2_80),
      .factorial4_80 (factorial4_80),
      .cos_value_80  (cos_value_80),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_cos       (out_cos),
      .out_err       (out_err)
   );

   // ---------------- clock ----------------
   always #5 clk_80 = ~clk_80;
   always @(posedge clk_80) cyc <= cyc + 1;

   // ---------------- core stand-in: 1 - x^2/2 + x^4/24 in Q1.7 ----------------
   function automatic logic [7:0] core_mag(input logic [7:0] r);
      int x, x2, x4, v;
      x  = int'(r);
      x2 = (x * x) >> 7;
      x4 = (x2 * x2) >> 7;
      v  = 128 - x2 / 2 + x4 / 24;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      return v[7:0];
   endfunction

   always @(posedge clk_80) begin
      s1 <= radian_80;
      s2 <= s1;
      s3 <= s2;
      s4 <= s3;
   end
   assign cos_value_80 = core_mag(s4);

   // ---------------- reference helpers ----------------
   function automatic logic [9:0] expect_word(input logic [7:0] rad, input logic neg,
                                              input logic err);
      logic [8:0] m;
      m = {1'b0, core_mag(rad)};
      if (err) return 10'h200;
      if (neg) m = 9'd0 - m;
      return {1'b0, m};
   endfunction

   task automatic ref_model(input int d, output logic [7:0] rad, output logic neg,
                            output logic err);
      int r;
      r = 0; neg = 1'b0; err = 1'b0;
      if (d >= 360)      err = 1'b1;
      else if (d >= 270) r = 360 - d;
      else if (d >= 180) begin r = d - 180; neg = 1'b1; end
      else if (d >= 90)  begin r = 180 - d; neg = 1'b1; end
      else               r = d;
      rad = 8'((r * 143 + 32) >> 6);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_80);
      #1;
   endtask

   task automatic send(input int d, input logic [7:0] rad, input logic neg,
                       input logic err, input bit timed);
      int budget;
      in_valid = 1'b1;
      in_deg   = 9'(d);
      budget   = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
         tick();
         budget++;
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck low for deg %0d", d);
      end else begin
         tick();
         exp_q.push_back(expect_word(rad, neg, err));
         exp_t_q.push_back(timed ? cyc + 5 : -1);
         check("radian_80", 32'(radian_80), 32'(rad));
      end
   endtask

   task automatic drain(input string name);
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 200) begin
         tick();
         b++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- scoreboard: compare each popped head ----------------
   always @(negedge clk_80) begin
      logic [9:0] e;
      int         t;
      if (rst_80 && out_valid === 1'b1 && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h, expected none", {out_err, out_cos});
         end else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("result", 32'({out_err, out_cos}), 32'(e));
            if (t >= 0) check("result_latency", cyc, t);
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int         acc_n;
      int         seen;
      int         d;
      bit         acc;
      logic [7:0] rad;
      logic       neg, err;

      vecs[0]  = '{0,   8'd0,   1'b0, 1'b0};
      vecs[1]  = '{180, 8'd0,   1'b1, 1'b0};
      vecs[2]  = '{90,  8'd201, 1'b1, 1'b0};
      vecs[3]  = '{45,  8'd101, 1'b0, 1'b0};
      vecs[4]  = '{270, 8'd201, 1'b0, 1'b0};
      vecs[5]  = '{300, 8'd134, 1'b0, 1'b0};
      vecs[6]  = '{359, 8'd2,   1'b0, 1'b0};
      vecs[7]  = '{135, 8'd101, 1'b1, 1'b0};
      vecs[8]  = '{400, 8'd0,   1'b0, 1'b1};
      vecs[9]  = '{0,   8'd0,   1'b0, 1'b0};
      vecs[10] = '{89,  8'd199, 1'b0, 1'b0};
      vecs[11] = '{91,  8'd199, 1'b1, 1'b0};
      vecs[12] = '{179, 8'd2,   1'b1, 1'b0};
      vecs[13] = '{181, 8'd2,   1'b1, 1'b0};
      vecs[14] = '{269, 8'd199, 1'b1, 1'b0};
      vecs[15] = '{360, 8'd0,   1'b0, 1'b1};
      vecs[16] = '{1,   8'd2,   1'b0, 1'b0};

      // reset values
      repeat (3) tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_cos", 32'(out_cos), 0);
      check("rst_out_err", 32'(out_err), 0);
      check("rst_radian", 32'(radian_80), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("factorial2", 32'(factorial2_80), 2);
      check("factorial4", 32'(factorial4_80), 24);
      @(negedge clk_80);
      rst_80 = 1'b1;
      seen = 0;
      while (in_ready !== 1'b1 && seen < 10) begin
         tick();
         seen++;
      end
      check("in_ready_after_reset", 32'(in_ready), 1);

      // directed table, back-to-back, no backpressure: fixed 5-cycle latency
      out_ready = 1'b1;
      foreach (vecs[i]) send(vecs[i].deg, vecs[i].rad, vecs[i].neg, vecs[i].err, 1'b1);
      in_valid = 1'b0;
      drain("table_drain");

      // backpressure: exactly FIFO_DEPTH accepted, then ready stays low
      out_ready = 1'b0;
      acc_n = 0;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         d = k * 17;
         in_deg = 9'(d);
         acc = (in_ready === 1'b1);
         tick();
         if (acc) begin
            ref_model(d, rad, neg, err);
            exp_q.push_back(expect_word(rad, neg, err));
            exp_t_q.push_back(-1);
            acc_n++;
         end
      end
      in_valid = 1'b0;
      check("bp_accepted", acc_n, 8);
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_fifo_full_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      drain("bp_drain");
      tick();
      check("bp_empty_after_drain", 32'(out_valid), 0);
      check("bp_in_ready_back", 32'(in_ready), 1);

      // random traffic against the reference model
      for (int k = 0; k < 10000; k++) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         d         = int'($urandom_range(0, 399));
         in_deg    = 9'(d);
         acc       = in_valid && (in_ready === 1'b1);
         tick();
         if (acc) begin
            ref_model(d, rad, neg, err);
            exp_q.push_back(expect_word(rad, neg, err));
            exp_t_q.push_back(-1);
            check("rand_radian", 32'(radian_80), 32'(rad));
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("rand_drain");

      // reset with 2 results in the FIFO and 3 tokens in flight
      out_ready = 1'b0;
      send(30, 8'd67, 1'b0, 1'b0, 1'b0);
      send(60, 8'd134, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      repeat (7) tick();
      send(10, 8'd22, 1'b0, 1'b0, 1'b0);
      send(20, 8'd45, 1'b0, 1'b0, 1'b0);
      send(40, 8'd89, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      check("mid_fifo_nonempty", 32'(out_valid), 1);
      rst_80 = 1'b0;
      #2;
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_out_cos", 32'(out_cos), 0);
      check("mid_rst_radian", 32'(radian_80), 0);
      check("mid_rst_in_ready", 32'(in_ready), 0);
      exp_q.delete();
      exp_t_q.delete();
      repeat (3) tick();
      @(negedge clk_80);
      rst_80    = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      check("no_stale_after_reset", seen, 0);
      check("ready_after_mid_reset", 32'(in_ready), 1);

      // one fresh token after the mid-operation reset
      send(0, 8'd0, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      drain("post_reset_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
